// File: rtl/ej32_pkg.sv
// Shared EJ32 types: stack opcodes issued by the arithmetic unit and data-stack sizing.
package ej32_pkg;

  typedef enum logic [1:0] {
    sNOP  = 2'd0,
    sPOP  = 2'd1,
    sPUSH = 2'd2,
    sMOVE = 2'd3
  } stack_op;

  localparam int SS_DEPTH_DFLT = 32;
  localparam int DSZ_DFLT      = 32;
  localparam int SS_AW         = $clog2(SS_DEPTH_DFLT);

endpackage

// File: rtl/ej32_ebr_1r1w.sv
// Synchronous simple dual-port RAM (one read, one write port), one-cycle read latency.
// A same-cycle write to the read address is forwarded to rq (write-first); the array has no reset.
module ej32_ebr_1r1w #(
  parameter int DEPTH = 32,
  parameter int DSZ   = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           we,
  input  logic [AW-1:0]  wa,
  input  logic [DSZ-1:0] wd,
  input  logic [AW-1:0]  ra,
  output logic [DSZ-1:0] rq
);

  logic [DSZ-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wa] <= wd;
    end
  end

  always_ff @(posedge clk) begin
    if (we && (wa == ra)) begin
      rq <= wd;
    end else begin
      rq <= mem[ra];
    end
  end

endmodule

// File: rtl/ej32_dstack.sv
// Data stack: NOS/entry-2 cached in registers, deeper entries in a 1R1W EBR; zero-latency s_o/s2_o.
// No stalls: the RAM read address follows next-state top so rd_q always holds the entry below u_r.
module ej32_dstack
  import ej32_pkg::*;
#(
  parameter int SS_DEPTH = SS_DEPTH_DFLT,
  parameter int DSZ      = DSZ_DFLT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  stack_op                   op,
  input  logic [DSZ-1:0]            t,
  input  logic                      clr,
  output logic [DSZ-1:0]            s_o,
  output logic [DSZ-1:0]            s2_o,
  output logic [$clog2(SS_DEPTH):0] depth_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic                      ovf_o,
  output logic                      unf_o
);

  localparam int AW = $clog2(SS_DEPTH);
  localparam int DW = AW + 1;

  logic [DSZ-1:0] s_r, u_r, s_nxt, u_nxt;
  logic [DW-1:0]  depth, d_nxt;
  logic           ovf_r, unf_r, ovf_nxt, unf_nxt;
  logic           full, empty;

  logic           we;
  logic [AW-1:0]  wa, ra;
  logic [DSZ-1:0] rd_q;

  assign full  = (depth == DW'(SS_DEPTH));
  assign empty = (depth == '0);

  // u_r spills to the slot just above the current RAM top (depth-3), i.e. address depth-2.
  assign wa = depth[AW-1:0] - AW'(2);
  // Reading the next-state top keeps rd_q aligned with u_r's successor, including after a PUSH via bypass.
  assign ra = d_nxt[AW-1:0] - AW'(3);

  always_comb begin
    s_nxt   = s_r;
    u_nxt   = u_r;
    d_nxt   = depth;
    ovf_nxt = ovf_r;
    unf_nxt = unf_r;
    we      = 1'b0;
    if (clr) begin
      s_nxt = '0;
      u_nxt = '0;
      d_nxt = '0;
    end else if (en) begin
      case (op)
        sPUSH: begin
          if (full) begin
            ovf_nxt = 1'b1;
          end else begin
            we    = (depth >= DW'(2));
            u_nxt = s_r;
            s_nxt = t;
            d_nxt = depth + DW'(1);
          end
        end
        sPOP: begin
          if (empty) begin
            unf_nxt = 1'b1;
          end else begin
            s_nxt = u_r;
            u_nxt = (depth >= DW'(3)) ? rd_q : '0;
            d_nxt = depth - DW'(1);
          end
        end
        sMOVE: begin
          if (empty) begin
            unf_nxt = 1'b1;
          end else begin
            s_nxt = t;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_r   <= '0;
      u_r   <= '0;
      depth <= '0;
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else begin
      s_r   <= s_nxt;
      u_r   <= u_nxt;
      depth <= d_nxt;
      ovf_r <= ovf_nxt;
      unf_r <= unf_nxt;
    end
  end

  ej32_ebr_1r1w #(
    .DEPTH (SS_DEPTH),
    .DSZ   (DSZ)
  ) u_ram (
    .clk (clk),
    .we  (we),
    .wa  (wa),
    .wd  (u_r),
    .ra  (ra),
    .rq  (rd_q)
  );

  assign s_o     = s_r;
  assign s2_o    = u_r;
  assign depth_o = depth;
  assign full_o  = full;
  assign empty_o = empty;
  assign ovf_o   = ovf_r;
  assign unf_o   = unf_r;

endmodule

// File: tb/tb_ej32_dstack.sv
// Randomized plus directed bench for ej32_dstack against a queue-based stack model.
module tb_ej32_dstack;
  import ej32_pkg::*;

  localparam int SS_DEPTH = 32;
  localparam int DSZ      = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b0;
  stack_op        op = sNOP;
  logic [DSZ-1:0] t = '0;
  logic           clr = 1'b0;
  logic [DSZ-1:0] s_o, s2_o;
  logic [5:0]     depth_o;
  logic           full_o, empty_o, ovf_o, unf_o;

  int checks = 0;
  int errors = 0;

  // Reference: element 0 is NOS, element 1 is the entry below it, and so on.
  logic [DSZ-1:0] mdl[$];
  logic           m_ovf, m_unf;

  always #5 clk = ~clk;

  ej32_dstack #(.SS_DEPTH(SS_DEPTH), .DSZ(DSZ)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .op      (op),
    .t       (t),
    .clr     (clr),
    .s_o     (s_o),
    .s2_o    (s2_o),
    .depth_o (depth_o),
    .full_o  (full_o),
    .empty_o (empty_o),
    .ovf_o   (ovf_o),
    .unf_o   (unf_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DSZ-1:0] m_nos();
    return (mdl.size() >= 1) ? mdl[0] : '0;
  endfunction

  function automatic logic [DSZ-1:0] m_e2();
    return (mdl.size() >= 2) ? mdl[1] : '0;
  endfunction

  task automatic model_reset();
    mdl.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_step(input logic e, input stack_op o, input logic [DSZ-1:0] v, input logic c);
    if (c) begin
      mdl.delete();
    end else if (e) begin
      case (o)
        sPUSH: if (mdl.size() == SS_DEPTH) m_ovf = 1'b1; else mdl.push_front(v);
        sPOP:  if (mdl.size() == 0) m_unf = 1'b1; else void'(mdl.pop_front());
        sMOVE: if (mdl.size() == 0) m_unf = 1'b1; else mdl[0] = v;
        default: ;
      endcase
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".s"},     64'(s_o),     64'(m_nos()));
    chk({tag, ".s2"},    64'(s2_o),    64'(m_e2()));
    chk({tag, ".depth"}, 64'(depth_o), 64'(mdl.size()));
    chk({tag, ".full"},  64'(full_o),  64'(mdl.size() == SS_DEPTH));
    chk({tag, ".empty"}, 64'(empty_o), 64'(mdl.size() == 0));
    chk({tag, ".ovf"},   64'(ovf_o),   64'(m_ovf));
    chk({tag, ".unf"},   64'(unf_o),   64'(m_unf));
  endtask

  // Inputs change just after the falling edge; outputs are sampled on the next falling edge.
  task automatic step(input string tag, input logic e, input stack_op o, input logic [DSZ-1:0] v, input logic c);
    en  = e;
    op  = o;
    t   = v;
    clr = c;
    @(posedge clk);
    model_step(e, o, v, c);
    @(negedge clk);
    en  = 1'b0;
    op  = sNOP;
    clr = 1'b0;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [DSZ-1:0] pre_s, pre_s2;
    int r;

    model_reset();
    do_reset();
    check_all("reset");

    // push 1..4 then pop x3
    for (int i = 1; i <= 4; i++) step("push4", 1'b1, sPUSH, DSZ'(i), 1'b0);
    chk("p4.s", 64'(s_o), 64'd4);
    chk("p4.s2", 64'(s2_o), 64'd3);
    chk("p4.depth", 64'(depth_o), 64'd4);
    for (int i = 0; i < 3; i++) begin
      step("pop3", 1'b1, sPOP, '0, 1'b0);
      chk("pop3.s", 64'(s_o), 64'(3 - i));
      chk("pop3.s2", 64'(s2_o), 64'(2 - i));
    end
    chk("pop3.depth", 64'(depth_o), 64'd1);

    // alternating PUSH/POP around depth 5 exercises the write/read bypass
    for (int i = 0; i < 4; i++) step("fill5", 1'b1, sPUSH, DSZ'(16 + i), 1'b0);
    pre_s  = s_o;
    pre_s2 = s2_o;
    for (int i = 0; i < 8; i++) begin
      step("alt.push", 1'b1, sPUSH, 32'hA5, 1'b0);
      chk("alt.d6", 64'(depth_o), 64'd6);
      step("alt.pop", 1'b1, sPOP, '0, 1'b0);
      chk("alt.s", 64'(s_o), 64'(pre_s));
      chk("alt.s2", 64'(s2_o), 64'(pre_s2));
      chk("alt.d5", 64'(depth_o), 64'd5);
    end

    // fill to full, overflow, drain past empty
    do_reset();
    for (int i = 0; i < SS_DEPTH; i++) step("fill", 1'b1, sPUSH, DSZ'(i), 1'b0);
    step("ovf", 1'b1, sPUSH, 32'hDEAD, 1'b0);
    chk("ovf.full", 64'(full_o), 64'd1);
    chk("ovf.flag", 64'(ovf_o), 64'd1);
    chk("ovf.depth", 64'(depth_o), 64'd32);
    chk("ovf.s", 64'(s_o), 64'd31);
    for (int i = 0; i < SS_DEPTH; i++) begin
      step("drain", 1'b1, sPOP, '0, 1'b0);
      chk("drain.s", 64'(s_o), (i < 31) ? 64'(30 - i) : 64'd0);
    end
    chk("drain.empty", 64'(empty_o), 64'd1);

    step("unf", 1'b1, sPOP, '0, 1'b0);
    chk("unf.flag", 64'(unf_o), 64'd1);
    chk("unf.depth", 64'(depth_o), 64'd0);
    step("unf.push", 1'b1, sPUSH, 32'd7, 1'b0);
    chk("unf.push.s", 64'(s_o), 64'd7);
    chk("unf.sticky", 64'(unf_o), 64'd1);

    // MOVE at depth 3, then MOVE with clr
    step("mv.p", 1'b1, sPUSH, 32'd8, 1'b0);
    step("mv.p", 1'b1, sPUSH, 32'd9, 1'b0);
    pre_s2 = s2_o;
    step("move", 1'b1, sMOVE, 32'h55, 1'b0);
    chk("move.s", 64'(s_o), 64'h55);
    chk("move.s2", 64'(s2_o), 64'(pre_s2));
    chk("move.depth", 64'(depth_o), 64'd3);
    step("move.clr", 1'b1, sMOVE, 32'h66, 1'b1);
    chk("clr.depth", 64'(depth_o), 64'd0);
    chk("clr.s", 64'(s_o), 64'd0);
    chk("clr.keep_unf", 64'(unf_o), 64'd1);

    // async reset with a POP in flight at depth 10
    for (int i = 0; i < 10; i++) step("pre.rst", 1'b1, sPUSH, DSZ'(100 + i), 1'b0);
    en = 1'b1;
    op = sPOP;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst.s", 64'(s_o), 64'd0);
    chk("arst.s2", 64'(s2_o), 64'd0);
    chk("arst.depth", 64'(depth_o), 64'd0);
    chk("arst.ovf", 64'(ovf_o), 64'd0);
    chk("arst.unf", 64'(unf_o), 64'd0);
    @(negedge clk);
    en = 1'b0;
    op = sNOP;
    rst_n = 1'b1;
    @(negedge clk);
    step("arst.push", 1'b1, sPUSH, 32'd9, 1'b0);
    chk("arst.push.s", 64'(s_o), 64'd9);
    chk("arst.push.s2", 64'(s2_o), 64'd0);

    // random phases: push-heavy, balanced, pop-heavy
    for (int ph = 0; ph < 3; ph++) begin
      for (int n = 0; n < 700; n++) begin
        stack_op o;
        r = $urandom_range(0, 99);
        if (r < (ph == 0 ? 60 : ph == 1 ? 35 : 20))      o = sPUSH;
        else if (r < (ph == 0 ? 80 : ph == 1 ? 70 : 75)) o = sPOP;
        else if (r < 90)                                 o = sMOVE;
        else                                             o = sNOP;
        step("rnd", ($urandom_range(0, 9) != 0), o, $urandom, ($urandom_range(0, 199) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
